// File: rtl/count_seq_monitor.sv
// Sequence checker for a 4-bit up-counter: verifies +1 mod 16 steps, counts wraps, latches first fault.
// Define COUNT_SEQ_MONITOR_HOLD_EN to accept a repeated value (stalled counter) while tracking.
module count_seq_monitor #(
    parameter int unsigned WRAP_W = 8
) (
    input  logic              Clk,
    input  logic              RST,
    input  logic [3:0]        CNT_IN,
    input  logic              SAMPLE,
    input  logic              CLR_ERR,
    output logic              WRAP,
    output logic [WRAP_W-1:0] WRAPS,
    output logic              ERR,
    output logic [3:0]        ERR_VAL,
    output logic [3:0]        ERR_EXP,
    output logic              LOCKED
);

    typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

    state_e              state_q, state_d;
    logic [3:0]          prev_q, prev_d;
    logic                wrap_q, wrap_d;
    logic [WRAP_W-1:0]   wraps_q, wraps_d;
    logic                err_q, err_d;
    logic [3:0]          err_val_q, err_val_d;
    logic [3:0]          err_exp_q, err_exp_d;
    logic [3:0]          exp_val;
    logic                hold_ok;

    assign exp_val = prev_q + 4'd1;

`ifdef COUNT_SEQ_MONITOR_HOLD_EN
    assign hold_ok = (CNT_IN == prev_q);
`else
    assign hold_ok = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        wrap_d    = 1'b0;
        wraps_d   = wraps_q;
        err_d     = err_q;
        err_val_d = err_val_q;
        err_exp_d = err_exp_q;
        if (CLR_ERR) begin
            err_d     = 1'b0;
            err_val_d = 4'd0;
            err_exp_d = 4'd0;
            // A sample arriving with the clear re-seeds the reference immediately.
            if (SAMPLE) begin
                prev_d  = CNT_IN;
                state_d = StTrack;
            end else begin
                state_d = StIdle;
            end
        end else if (SAMPLE) begin
            unique case (state_q)
                StIdle: begin
                    prev_d  = CNT_IN;
                    state_d = StTrack;
                end
                StTrack: begin
                    if (CNT_IN == exp_val) begin
                        prev_d = CNT_IN;
                        if (prev_q == 4'hf) begin
                            wrap_d = 1'b1;
                            if (wraps_q != '1) begin
                                wraps_d = wraps_q + WRAP_W'(1);
                            end
                        end
                    end else if (!hold_ok) begin
                        err_d     = 1'b1;
                        err_val_d = CNT_IN;
                        err_exp_d = exp_val;
                        prev_d    = CNT_IN;
                        state_d   = StFault;
                    end
                end
                StFault: begin
                    prev_d = CNT_IN;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q   <= StIdle;
            prev_q    <= 4'd0;
            wrap_q    <= 1'b0;
            wraps_q   <= '0;
            err_q     <= 1'b0;
            err_val_q <= 4'd0;
            err_exp_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            wrap_q    <= wrap_d;
            wraps_q   <= wraps_d;
            err_q     <= err_d;
            err_val_q <= err_val_d;
            err_exp_q <= err_exp_d;
        end
    end

    assign WRAP    = wrap_q;
    assign WRAPS   = wraps_q;
    assign ERR     = err_q;
    assign ERR_VAL = err_val_q;
    assign ERR_EXP = err_exp_q;
    assign LOCKED  = (state_q == StTrack);

endmodule

// File: tb/tb_count_seq_monitor.sv
// Self-checking bench: two monitors (WRAP_W=8 and WRAP_W=2) share stimulus and are compared
// against a behavioural model of the sequence rules.
module tb_count_seq_monitor;

    logic       Clk = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] CNT_IN = 4'd0;
    logic       SAMPLE = 1'b0;
    logic       CLR_ERR = 1'b0;

    logic       a_wrap, a_err, a_locked;
    logic [7:0] a_wraps;
    logic [3:0] a_err_val, a_err_exp;
    logic       b_wrap, b_err, b_locked;
    logic [1:0] b_wraps;
    logic [3:0] b_err_val, b_err_exp;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = no reference, 1 = tracking, 2 = faulted
    int m_mode, m_prev, m_wraps, m_val, m_exp;
    bit m_wrap, m_err;

    count_seq_monitor #(.WRAP_W(8)) dut_a (
        .Clk(Clk), .RST(RST), .CNT_IN(CNT_IN), .SAMPLE(SAMPLE), .CLR_ERR(CLR_ERR),
        .WRAP(a_wrap), .WRAPS(a_wraps), .ERR(a_err), .ERR_VAL(a_err_val),
        .ERR_EXP(a_err_exp), .LOCKED(a_locked)
    );

    count_seq_monitor #(.WRAP_W(2)) dut_b (
        .Clk(Clk), .RST(RST), .CNT_IN(CNT_IN), .SAMPLE(SAMPLE), .CLR_ERR(CLR_ERR),
        .WRAP(b_wrap), .WRAPS(b_wraps), .ERR(b_err), .ERR_VAL(b_err_val),
        .ERR_EXP(b_err_exp), .LOCKED(b_locked)
    );

    always #5 Clk = ~Clk;

    function automatic void model_edge(input bit rst, input bit clr, input bit smp, input int cnt);
        bit hold;
`ifdef COUNT_SEQ_MONITOR_HOLD_EN
        hold = 1'b1;
`else
        hold = 1'b0;
`endif
        if (rst) begin
            m_mode = 0; m_prev = 0; m_wraps = 0; m_val = 0; m_exp = 0;
            m_wrap = 0; m_err = 0;
            return;
        end
        m_wrap = 0;
        if (clr) begin
            m_err = 0; m_val = 0; m_exp = 0;
            m_mode = smp ? 1 : 0;
            if (smp) m_prev = cnt;
        end else if (smp) begin
            if (m_mode == 1) begin
                if (cnt == (m_prev + 1) % 16) begin
                    if (m_prev == 15) begin
                        m_wrap = 1;
                        m_wraps++;
                    end
                end else if (!(hold && cnt == m_prev)) begin
                    m_err = 1; m_val = cnt; m_exp = (m_prev + 1) % 16; m_mode = 2;
                end
            end else if (m_mode == 0) begin
                m_mode = 1;
            end
            m_prev = cnt;
        end
    endfunction

    task automatic step(input bit rst, input bit clr, input bit smp, input int cnt);
        @(negedge Clk);
        RST = rst; CLR_ERR = clr; SAMPLE = smp; CNT_IN = 4'(cnt);
        @(posedge Clk);
        model_edge(rst, clr, smp, cnt);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 1, 5);
        checks++; if (a_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", a_wrap); end
        checks++; if (a_wraps !== 8'd0) begin errors++; $display("FAIL reset_wraps got %0d want 0", a_wraps); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", a_err); end
        checks++; if ({a_err_val, a_err_exp} !== 8'd0) begin
            errors++; $display("FAIL reset_errval got %h/%h want 0/0", a_err_val, a_err_exp); end
        checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", a_locked); end
        checks++; if ({b_wrap, b_wraps, b_err, b_locked} !== 5'd0) begin
            errors++; $display("FAIL reset_b got %b want 0", {b_wrap, b_wraps, b_err, b_locked}); end
    endtask

    task automatic test_count_up();
        int pulses = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            step(0, 0, 1, i % 16);
            if (a_wrap) pulses++;
            checks++; if (a_locked !== 1'b1 || a_err !== 1'b0) begin
                errors++; $display("FAIL up_lock[%0d] got lock=%b err=%b want 1/0", i, a_locked, a_err); end
            checks++; if (a_wrap !== m_wrap) begin
                errors++; $display("FAIL up_wrap[%0d] got %b want %b", i, a_wrap, m_wrap); end
        end
        checks++; if (pulses != 1 || a_wraps !== 8'd1) begin
            errors++; $display("FAIL up_wraps got pulses=%0d wraps=%0d want 1/1", pulses, a_wraps); end
    endtask

    task automatic test_fault();
        int pulses = 0;
        step(1, 0, 0, 0);
        step(0, 0, 1, 3);
        step(0, 0, 1, 4);
        step(0, 0, 1, 6);
        checks++; if (a_err !== 1'b1 || a_locked !== 1'b0) begin
            errors++; $display("FAIL fault_flag got err=%b lock=%b want 1/0", a_err, a_locked); end
        checks++; if (a_err_val !== 4'd6 || a_err_exp !== 4'd5) begin
            errors++; $display("FAIL fault_vals got %0d/%0d want 6/5", a_err_val, a_err_exp); end
        for (int v = 7; v <= 16; v++) begin
            step(0, 0, 1, v % 16);
            if (a_wrap) pulses++;
        end
        checks++; if (pulses != 0 || a_wraps !== 8'd0) begin
            errors++; $display("FAIL fault_frozen got pulses=%0d wraps=%0d want 0/0", pulses, a_wraps); end
        checks++; if (a_err_val !== 4'd6 || a_err_exp !== 4'd5 || a_err !== 1'b1) begin
            errors++; $display("FAIL fault_held got %b %0d/%0d want 1 6/5", a_err, a_err_val, a_err_exp); end
    endtask

    task automatic test_clear();
        step(0, 1, 1, 9);
        checks++; if (a_err !== 1'b0 || a_locked !== 1'b1 || a_err_val !== 4'd0) begin
            errors++; $display("FAIL clear_seed got err=%b lock=%b val=%0d want 0/1/0", a_err, a_locked, a_err_val); end
        step(0, 0, 1, 10);
        step(0, 0, 1, 11);
        checks++; if (a_err !== 1'b0 || a_locked !== 1'b1) begin
            errors++; $display("FAIL clear_track got err=%b lock=%b want 0/1", a_err, a_locked); end
        step(0, 1, 0, 3);
        checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL clear_idle got lock=%b want 0", a_locked); end
    endtask

    task automatic test_hold();
        step(1, 0, 0, 0);
        step(0, 0, 1, 5);
        step(0, 0, 1, 5);
        step(0, 0, 1, 6);
`ifdef COUNT_SEQ_MONITOR_HOLD_EN
        checks++; if (a_err !== 1'b0 || a_locked !== 1'b1) begin
            errors++; $display("FAIL hold_ok got err=%b lock=%b want 0/1", a_err, a_locked); end
`else
        checks++; if (a_err !== 1'b1 || a_err_val !== 4'd5 || a_err_exp !== 4'd6) begin
            errors++; $display("FAIL hold_fault got %b %0d/%0d want 1 5/6", a_err, a_err_val, a_err_exp); end
`endif
    endtask

    task automatic test_saturate();
        int pulses = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i <= 64; i++) begin
            step(0, 0, 1, i % 16);
            if (b_wrap) begin
                pulses++;
                if (pulses == 3) begin
                    checks++; if (b_wraps !== 2'd3) begin
                        errors++; $display("FAIL sat_third got %0d want 3", b_wraps); end
                end
            end
        end
        checks++; if (pulses != 4 || b_wraps !== 2'd3) begin
            errors++; $display("FAIL sat_fourth got pulses=%0d wraps=%0d want 4/3", pulses, b_wraps); end
        checks++; if (a_wraps !== 8'd4) begin errors++; $display("FAIL sat_wide got %0d want 4", a_wraps); end
    endtask

    task automatic test_rst_mid();
        step(1, 0, 0, 0);
        step(0, 0, 1, 3);
        step(0, 0, 1, 5);
        step(0, 0, 1, 6);
        step(0, 0, 1, 7);
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", a_err); end
        step(1, 0, 1, 7);
        checks++; if ({a_wrap, a_wraps, a_err, a_err_val, a_err_exp, a_locked} !== 19'd0) begin
            errors++; $display("FAIL rstmid_zero got %h want 0",
                               {a_wrap, a_wraps, a_err, a_err_val, a_err_exp, a_locked}); end
        step(0, 0, 1, 12);
        checks++; if (a_locked !== 1'b1 || a_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_seed got lock=%b err=%b want 1/0", a_locked, a_err); end
        step(0, 0, 1, 13);
        checks++; if (a_locked !== 1'b1 || a_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_next got lock=%b err=%b want 1/0", a_locked, a_err); end
    endtask

    task automatic test_random();
        step(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            bit rst = ($urandom_range(0, 79) == 0);
            bit clr = ($urandom_range(0, 29) == 0);
            bit smp = ($urandom_range(0, 3) != 0);
            int cnt = (m_prev + 1) % 16;
            int r = $urandom_range(0, 19);
            if (r == 0) cnt = $urandom_range(0, 15);
            else if (r == 1) cnt = m_prev;
            step(rst, clr, smp, cnt);
            checks++; if (a_wrap !== m_wrap || b_wrap !== m_wrap) begin
                errors++; $display("FAIL rand_wrap[%0d] got %b/%b want %b", i, a_wrap, b_wrap, m_wrap); end
            checks++; if (a_wraps !== 8'((m_wraps > 255) ? 255 : m_wraps) ||
                          b_wraps !== 2'((m_wraps > 3) ? 3 : m_wraps)) begin
                errors++; $display("FAIL rand_wraps[%0d] got %0d/%0d want count %0d", i, a_wraps, b_wraps, m_wraps); end
            checks++; if (a_err !== m_err || a_err_val !== 4'(m_val) || a_err_exp !== 4'(m_exp)) begin
                errors++; $display("FAIL rand_err[%0d] got %b %0d/%0d want %b %0d/%0d",
                                   i, a_err, a_err_val, a_err_exp, m_err, m_val, m_exp); end
            checks++; if (a_locked !== (m_mode == 1) || b_locked !== a_locked) begin
                errors++; $display("FAIL rand_lock[%0d] got %b/%b want %b", i, a_locked, b_locked, m_mode == 1); end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_fault();
        test_clear();
        test_hold();
        test_saturate();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
